hex_display_ctrl: RTL and testbench
===================================

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of hex digits displayed (1..16).
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clock cycles per scan step (>=1).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: when 1, a lit segment drives 0.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_a  in  4*DIGITS  channel A value (e.g. SRAM data bus).
REQ-007 SHALL have port data_b  in  4*DIGITS  channel B value (e.g. SRAM address, zero-extended).
REQ-008 SHALL have port ch_sel  in  1  0 selects data_a, 1 selects data_b.
REQ-009 SHALL have port hold  in  1  1 freezes the display value; 0 gives live mode.
REQ-010 SHALL have port capture  in  1  load strobe, used only when hold=1.
REQ-011 SHALL have port blank_lz  in  1  1 enables leading-zero blanking.
REQ-012 SHALL have port seg  out  8*DIGITS  static segments; byte i drives digit i (bits 0..6 = a..g, bit 7 = dp).
REQ-013 SHALL have port scan_seg  out  8  segment byte of the currently scanned digit.
REQ-014 SHALL have port scan_an  out  DIGITS  one-hot, active-low digit enable.
REQ-015 SHALL have port captured  out  1  one-cycle pulse confirming a held load.

Function
REQ-016 SHALL register the display value disp_val (4*DIGITS bits).
- hold=0: load the channel chosen by ch_sel on every edge.
- hold=1: load it only on an edge where capture=1.
REQ-017 SHALL, while hold=0, ignore capture and keep captured at 0.
REQ-018 SHALL assert captured for exactly the cycle after each load made under hold=1 with capture=1; a capture held high for N cycles SHALL give N loads and N pulses.
REQ-019 SHALL keep the last disp_val when hold goes 0->1; no load occurs without capture.
REQ-020 SHALL register seg from disp_val, so total latency from an input change to seg is 2 cycles.
REQ-021 SHALL decode nibble values 0-F to standard hex glyphs (b and d lowercase).
REQ-022 SHALL keep dp unlit on every digit.
REQ-023 SHALL, when blank_lz=1, fully unlight every digit above the most significant non-zero nibble.
REQ-024 SHALL never blank digit 0, so a value of 0 shows a single "0".
REQ-025 SHALL apply blank_lz with the same 2-cycle latency as the data path.
REQ-026 SHALL invert all segment and glyph bits when SEG_ACTIVE_LOW=1.
REQ-027 SHALL use a prescaler counting 0..SCAN_DIV-1.
- At terminal count it wraps to 0 and the scan index advances; index DIGITS-1 wraps to 0.
- SCAN_DIV=1 SHALL advance the index on every cycle.
REQ-028 SHALL drive scan_an low only at bit [index], and drive scan_seg = seg byte [index], both combinational from registers.
REQ-029 SHALL size the prescaler and index to $clog2 of their ranges, with a minimum width of 1.

Reset
REQ-030 SHALL, on reset assertion, immediately set without waiting for clock:
- disp_val = 0, prescaler = 0, index = 0, captured = 0;
- seg = all segments unlit;
- scan_an = only bit 0 low.
REQ-031 SHALL, on reset mid-scan or mid-capture, abandon the pending load and resume the scan from digit 0 after deassertion.
REQ-032 SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-033 SHALL place in the shared display package:
- the segment bit-position constants;
- the 16-entry glyph table;
- the blank-glyph constant.
REQ-034 SHALL implement nibble-to-glyph decode in sub-module hex_seg_decoder (nibble, blank, active_low -> 8-bit seg), instantiated DIGITS times.

Verification
REQ-035 Bench SHALL use DIGITS=8, SCAN_DIV=4, SEG_ACTIVE_LOW=1 and cover these scenarios:
- Live mode: hold=0, ch_sel=0, data_a=32'h1234ABCD -> 2 cycles later seg digit7 = glyph 1 (8'hF9) and digit0 = glyph d (8'hA1).
- Channel switch: data_b=32'h000F_0000, toggle ch_sel 0->1 -> seg switches exactly 2 cycles later; digit4 = glyph F (8'h8E).
- Hold/capture: hold=1; change data_a to 32'hDEADBEEF with capture=0 -> seg unchanged; pulse capture for 1 cycle -> captured high for exactly 1 cycle and seg shows DEADBEEF.
- Leading-zero blanking: blank_lz=1, data_a=32'h00000050 -> digits 7..2 = 8'hFF, digit1 = glyph 5 (8'h92), digit0 = glyph 0 (8'hC0); data_a=0 -> only digit0 lit, showing "0".
- Scan timing: scan_an steps FE,FD,...,7F,FE every 4 cycles; scan_seg always equals the seg byte of the active digit.
- Async reset: assert reset mid-scan between clock edges -> outputs take reset values before the next edge; after deassertion the scan restarts at digit 0.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: segment bit positions, active-high hex glyph table and blank glyph
package hex_display_pkg;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam logic [15:0][7:0] GLYPHS = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };
  localparam logic [7:0] SEG_BLANK = 8'h00;
endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: nibble -> 8-bit segment byte (a..g, dp), optional blank and active-low inversion
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       active_low,
  output logic [7:0] seg
);
  assign seg = (blank ? SEG_BLANK : GLYPHS[nibble]) ^ {8{active_low}};
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: A/B hex display with hold/capture, leading-zero blanking, static seg and scanned scan_seg/scan_an outputs
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_a,
  input  logic [4*DIGITS-1:0]   data_b,
  input  logic                  ch_sel,
  input  logic                  hold,
  input  logic                  capture,
  input  logic                  blank_lz,
  output logic [8*DIGITS-1:0]   seg,
  output logic [7:0]            scan_seg,
  output logic [DIGITS-1:0]     scan_an,
  output logic                  captured
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  logic [4*DIGITS-1:0] disp_val;
  logic                blank_q;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       index;
  logic [8*DIGITS-1:0] seg_d;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic                tc;
  assign load = !hold || capture;
  assign tc   = presc == PW'(SCAN_DIV - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_val <= '0;
      blank_q  <= 1'b0;
      captured <= 1'b0;
      seg      <= {DIGITS{OFF}};
      presc    <= '0;
      index    <= '0;
    end else begin
      if (load) disp_val <= ch_sel ? data_b : data_a;
      blank_q  <= blank_lz;
      captured <= hold && capture;
      seg      <= seg_d;
      presc    <= tc ? '0 : presc + PW'(1);
      if (tc) index <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_lsd
      assign blank[g] = 1'b0;
    end else begin : g_hi
      assign blank[g] = blank_q && ~|disp_val[4*DIGITS-1:4*g];
    end
    hex_seg_decoder u_dec (
      .nibble    (disp_val[4*g +: 4]),
      .blank     (blank[g]),
      .active_low(SEG_ACTIVE_LOW),
      .seg       (seg_d[8*g +: 8])
    );
  end
  assign scan_seg = seg[8*index +: 8];
  assign scan_an  = ~(DIGITS'(1) << index);
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: table/scoreboard bench for hex_display_ctrl (DIGITS=8, SCAN_DIV=4, active-low)
module tb_hex_display_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        ch_sel = 1'b0;
  logic        hold = 1'b0;
  logic        capture = 1'b0;
  logic        blank_lz = 1'b0;
  logic [63:0] seg;
  logic [7:0]  scan_seg;
  logic [7:0]  scan_an;
  logic        captured;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {int due; logic [63:0] exp; int id;} sb_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic sel; logic blz; logic [63:0] exp;} vec_t;
  sb_t  q[$];
  vec_t vecs[8];
  localparam logic [63:0] V_1234 = 64'hF9A4B099_8883C6A1;
  localparam logic [63:0] V_DEAD = 64'hA18688A1_8386868E;
  localparam logic [63:0] ZEROS  = {8{8'hC0}};
  localparam logic [63:0] DARK   = {8{8'hFF}};

  hex_display_ctrl #(.DIGITS(8), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .clock(clk), .reset(rst), .data_a(data_a), .data_b(data_b), .ch_sel(ch_sel),
    .hold(hold), .capture(capture), .blank_lz(blank_lz), .seg(seg),
    .scan_seg(scan_seg), .scan_an(scan_an), .captured(captured)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      sb_t e;
      e = q.pop_front();
      check($sformatf("vec%0d_seg", e.id), seg, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] last;
    logic [63:0] es;
    int idx;
    vecs[0] = '{32'h1234ABCD, 32'h0,        1'b0, 1'b0, V_1234};
    vecs[1] = '{32'h1234ABCD, 32'h000F0000, 1'b1, 1'b0, 64'hC0C0C08E_C0C0C0C0};
    vecs[2] = '{32'h00000050, 32'h000F0000, 1'b0, 1'b1, 64'hFFFFFFFF_FFFF92C0};
    vecs[3] = '{32'h00000000, 32'h0,        1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFC0};
    vecs[4] = '{32'hDEADBEEF, 32'h0,        1'b0, 1'b0, V_DEAD};
    vecs[5] = '{32'h00000000, 32'h0,        1'b0, 1'b0, ZEROS};
    vecs[6] = '{32'h80000000, 32'h0,        1'b0, 1'b1, 64'h80C0C0C0_C0C0C0C0};
    vecs[7] = '{32'h0000F00D, 32'h0,        1'b0, 1'b1, 64'hFFFFFFFF_8EC0C0A1};
    #12;
    check("rst_seg", seg, DARK);
    check("rst_scan_an", {56'h0, scan_an}, 64'hFE);
    check("rst_scan_seg", {56'h0, scan_seg}, 64'hFF);
    check("rst_captured", {63'h0, captured}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("idle_seg", seg, ZEROS);
    last = ZEROS;
    for (int i = 0; i < 8; i++) begin
      tick();
      data_a = vecs[i].a;
      data_b = vecs[i].b;
      ch_sel = vecs[i].sel;
      blank_lz = vecs[i].blz;
      q.push_back('{cyc + 1, last, i});
      q.push_back('{cyc + 2, vecs[i].exp, i});
      last = vecs[i].exp;
      repeat (2) tick();
    end
    repeat (3) tick();
    check("sb_drain", 64'(q.size()), 64'h0);
    tick();
    blank_lz = 1'b0;
    ch_sel = 1'b0;
    data_a = 32'h1234ABCD;
    repeat (3) tick();
    hold = 1'b1;
    data_a = 32'hDEADBEEF;
    repeat (3) tick();
    @(negedge clk);
    check("hold_seg", seg, V_1234);
    check("hold_captured", {63'h0, captured}, 64'h0);
    tick();
    capture = 1'b1;
    @(negedge clk);
    check("cap_pre", {63'h0, captured}, 64'h0);
    tick();
    capture = 1'b0;
    @(negedge clk);
    check("cap_pulse", {63'h0, captured}, 64'h1);
    check("cap_seg_latency", seg, V_1234);
    tick();
    @(negedge clk);
    check("cap_end", {63'h0, captured}, 64'h0);
    check("cap_seg", seg, V_DEAD);
    tick();
    data_a = 32'h00000050;
    capture = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) capture = 1'b0;
      @(negedge clk);
      check($sformatf("multi_cap%0d", k), {63'h0, captured}, {63'h0, k <= 3});
    end
    check("multi_cap_seg", seg, 64'hC0C0C0C0_C0C092C0);
    tick();
    hold = 1'b0;
    capture = 1'b1;
    data_a = 32'h1234ABCD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("live_cap%0d", k), {63'h0, captured}, 64'h0);
      tick();
    end
    capture = 1'b0;
    repeat (5) tick();
    hold = 1'b1;
    capture = 1'b1;
    data_a = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_seg", seg, DARK);
    check("async_scan_an", {56'h0, scan_an}, 64'hFE);
    check("async_scan_seg", {56'h0, scan_seg}, 64'hFF);
    check("async_captured", {63'h0, captured}, 64'h0);
    hold = 1'b0;
    capture = 1'b0;
    data_a = 32'h1234ABCD;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      idx = (k / 4) % 8;
      es = k == 0 ? DARK : k == 1 ? ZEROS : V_1234;
      check($sformatf("scan_an%0d", k), {56'h0, scan_an}, {56'h0, ~(8'h01 << idx)});
      check($sformatf("scan_seg%0d", k), {56'h0, scan_seg}, {56'h0, es[8*idx +: 8]});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
